// File: rtl/bus_lsu.sv
// bus_lsu: single-beat load/store unit on a strobe/ack bus; define LSU_TIMEOUT_EN to add a STROBE watchdog
module bus_lsu #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_i,
  input  logic                req,
  input  logic                we,
  input  logic [1:0]          size,
  input  logic                sgn,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata,
  output logic                done,
  output logic [1:0]          err,
  output logic                busy,
  output logic [ADDR_W-1:0]   adr_o,
  output logic [DATA_W-1:0]   dat_o,
  output logic [DATA_W/8-1:0] sel_o,
  output logic                we_o,
  output logic                stb_o,
  input  logic [DATA_W-1:0]   dat_i,
  input  logic                ack_i
);
  localparam int SW = DATA_W / 8;
  localparam int LB = $clog2(SW);
  typedef enum logic [1:0] {IDLE, STROBE, RELEASE, RESP} state_t;
  state_t state, state_n;
  logic r_we, r_sgn, mis, tmo, sbit;
  logic [1:0] r_size;
  logic [LB-1:0] r_off;
  logic [SW-1:0] sel_n;
  logic [6:0] nb;
  logic [DATA_W-1:0] sh, mask, ld;
  assign mis = (|(addr[2:0] & ((3'd1 << size) - 3'd1))) || (size == 2'b11 && DATA_W == 32);
  assign sel_n = ((SW'(1) << (4'd1 << size)) - SW'(1)) << addr[LB-1:0];
`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  // watchdog: counts cycles spent in STROBE, cleared everywhere else
  always_ff @(posedge clk) begin
    cnt <= (rst_i || state != STROBE) ? '0 : cnt + 1'b1;
  end
  assign tmo = !ack_i && (cnt == CW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign tmo = 1'b0;
`endif
  // load alignment: shift selected lanes down, then zero- or sign-fill above the access width
  always_comb begin
    nb = 7'd8 << r_size;
    sh = dat_i >> {r_off, 3'b000};
    mask = (DATA_W'(1) << nb) - DATA_W'(1);
    sbit = |(sh & (mask ^ (mask >> 1)));
    ld = (sh & mask) | (~mask & {DATA_W{r_sgn & sbit}});
  end
  // state register
  always_ff @(posedge clk) begin
    state <= rst_i ? IDLE : state_n;
  end
  // next-state: RELEASE waits for the slave to drop ack before completing
  always_comb begin
    state_n = (state == IDLE)    ? (req ? (mis ? RESP : STROBE) : IDLE) :
              (state == STROBE)  ? (ack_i ? RELEASE : (tmo ? RESP : STROBE)) :
              (state == RELEASE) ? (ack_i ? RELEASE : RESP) : IDLE;
  end
  // state-decoded outputs
  always_comb begin
    done = state == RESP;
    busy = state != IDLE;
  end
  // request latch, bus drive and load capture
  always_ff @(posedge clk) begin
    if (rst_i) begin
      {r_we, r_sgn, r_size, r_off, err, stb_o, we_o} <= '0;
      adr_o <= '0;
      dat_o <= '0;
      sel_o <= '0;
      rdata <= '0;
    end else begin
      if (state == IDLE && req) begin
        r_we <= we;
        r_size <= size;
        r_sgn <= sgn;
        r_off <= addr[LB-1:0];
        err <= mis ? 2'b01 : 2'b00;
        if (!mis) begin
          stb_o <= 1'b1;
          we_o <= we;
          adr_o <= {addr[ADDR_W-1:LB], {LB{1'b0}}};
          sel_o <= sel_n;
          dat_o <= wdata << {addr[LB-1:0], 3'b000};
        end
      end
      if (state == STROBE && (ack_i || tmo)) begin
        stb_o <= 1'b0;
        we_o <= 1'b0;
        if (tmo) err <= 2'b10;
        if (ack_i && !r_we) rdata <= ld;
      end
    end
  end
endmodule

// File: tb/tb_bus_lsu.sv
// tb_bus_lsu: randomized scoreboard bench for bus_lsu against a byte-array memory model
module tb_bus_lsu;
  logic clk = 1'b0, rst_i = 1'b1, req = 1'b0, we = 1'b0, sgn = 1'b0, ack_i = 1'b0;
  logic [1:0] size = 2'b00, err;
  logic [31:0] addr = '0, wdata = '0, rdata, adr_o, dat_o, dat_i = '0;
  logic done, busy, we_o, stb_o;
  logic [3:0] sel_o;
  logic req64 = 1'b0, we64 = 1'b0, sgn64 = 1'b0, done64, busy64, weo64, stb64, ack64;
  logic [1:0] size64 = 2'b00, err64;
  logic [15:0] addr64 = '0, adr64;
  logic [63:0] wdata64 = '0, rdata64, datw64, dat64 = 64'h8877665544332211;
  logic [7:0] sel64;
  typedef struct {logic [1:0] e; logic [31:0] r;} exp_t;
  exp_t exp_q[$];
  logic [7:0] ref_mem[64];
  logic [31:0] bmem[16];
  logic [31:0] exp_rd = '0;
  int n_chk = 0, n_fail = 0, fix_dly = -1, fix_hold = -1;
  bit slave_on = 1'b1;

  always #5 clk = ~clk;

  bus_lsu #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_i(rst_i), .req(req), .we(we), .size(size), .sgn(sgn), .addr(addr),
    .wdata(wdata), .rdata(rdata), .done(done), .err(err), .busy(busy), .adr_o(adr_o),
    .dat_o(dat_o), .sel_o(sel_o), .we_o(we_o), .stb_o(stb_o), .dat_i(dat_i), .ack_i(ack_i)
  );

  bus_lsu #(.DATA_W(64), .ADDR_W(16)) u64 (
    .clk(clk), .rst_i(rst_i), .req(req64), .we(we64), .size(size64), .sgn(sgn64), .addr(addr64),
    .wdata(wdata64), .rdata(rdata64), .done(done64), .err(err64), .busy(busy64), .adr_o(adr64),
    .dat_o(datw64), .sel_o(sel64), .we_o(weo64), .stb_o(stb64), .dat_i(dat64), .ack_i(ack64)
  );
  assign ack64 = stb64;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic set_word(input int i, input logic [31:0] v);
    bmem[i] = v;
    for (int j = 0; j < 4; j++) ref_mem[4*i+j] = v[8*j+:8];
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      n_chk++;
      n_fail++;
      $display("FAIL idle_wait: busy still 1 after %0d cycles, expected 0", t);
    end
  endtask

  task automatic drive(input logic w, input logic [1:0] s, input logic g, input logic [31:0] a, input logic [31:0] d);
    we = w; size = s; sgn = g; addr = a; wdata = d; req = 1'b1;
    @(negedge clk);
    req = 1'b0; we = ~w; addr = $urandom; wdata = $urandom; size = ~s; sgn = ~g;
  endtask

  task automatic issue(input logic w, input logic [1:0] s, input logic g, input logic [31:0] a, input logic [31:0] d);
    int n = 1 << s;
    logic [63:0] v = '0;
    exp_t x;
    wait_idle();
    if ((a & 32'(n - 1)) != 0 || s == 2'b11) x.e = 2'b01;
    else begin
      x.e = 2'b00;
      if (w) for (int i = 0; i < n; i++) ref_mem[6'(a + 32'(i))] = d[8*i+:8];
      else begin
        for (int i = 0; i < n; i++) v = v | (64'(ref_mem[6'(a + 32'(i))]) << (8*i));
        if (g && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
        exp_rd = v[31:0];
      end
    end
    x.r = exp_rd;
    exp_q.push_back(x);
    drive(w, s, g, a, d);
  endtask

  task automatic lat_to_done(output int c);
    c = 1;
    while (!done && c < 60) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic wait_done64();
    int t = 0;
    while (!done64 && t < 20) begin
      @(negedge clk);
      t++;
    end
  endtask

  // scoreboard monitor: every completion must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t x;
    if (done) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL done_unexpected: got done=1 err=%0b, expected no completion", err);
      end else begin
        x = exp_q.pop_front();
        chk("err", 64'(err), 64'(x.e));
        chk("rdata", 64'(rdata), 64'(x.r));
      end
    end
  end

  // bus slave backed by a word memory, with configurable ack delay and hold
  initial forever begin
    int d, h;
    @(negedge clk);
    if (stb_o && slave_on) begin
      d = fix_dly >= 0 ? fix_dly : int'($urandom_range(0, 2));
      h = fix_hold >= 0 ? fix_hold : ($urandom_range(0, 4) == 0 ? 3 : 1);
      repeat (d) @(negedge clk);
      if (stb_o) begin
        ack_i = 1'b1;
        if (we_o) begin
          for (int j = 0; j < 4; j++) if (sel_o[j]) bmem[adr_o[5:2]][8*j+:8] = dat_o[8*j+:8];
        end else dat_i = bmem[adr_o[5:2]];
        repeat (h) @(negedge clk);
        ack_i = 1'b0;
        dat_i = $urandom;
      end
    end
  end

  initial begin
    int c;
    logic [1:0] s;
    logic [31:0] a;
    for (int i = 0; i < 16; i++) set_word(i, $urandom);
    repeat (2) @(negedge clk);
    chk("rst_stb", 64'(stb_o), 0);
    chk("rst_we", 64'(we_o), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_sel", 64'(sel_o), 0);
    chk("rst_adr", 64'(adr_o), 0);
    chk("rst_dat", 64'(dat_o), 0);
    chk("rst_rdata", 64'(rdata), 0);
    rst_i = 1'b0;
    size64 = 2'b11; addr64 = 16'h0008; sgn64 = 1'b0; req64 = 1'b1;
    @(negedge clk);
    req64 = 1'b0;
    chk("d64_sel", 64'(sel64), 64'hFF);
    chk("d64_adr", 64'(adr64), 64'h8);
    wait_done64();
    chk("d64_done", 64'(done64), 1);
    chk("d64_rdata", rdata64, 64'h8877665544332211);
    chk("d64_err", 64'(err64), 0);
    @(negedge clk);
    size64 = 2'b01; addr64 = 16'h0006; sgn64 = 1'b1; req64 = 1'b1;
    @(negedge clk);
    req64 = 1'b0;
    chk("h64_sel", 64'(sel64), 64'hC0);
    chk("h64_adr", 64'(adr64), 64'h0);
    wait_done64();
    chk("h64_rdata", rdata64, 64'hFFFFFFFFFFFF8877);
    @(negedge clk);
    size64 = 2'b11; addr64 = 16'h0004; req64 = 1'b1;
    @(negedge clk);
    req64 = 1'b0;
    chk("m64_stb", 64'(stb64), 0);
    wait_done64();
    chk("m64_err", 64'(err64), 1);
    @(negedge clk);
    fix_dly = 0;
    fix_hold = 1;
    set_word(0, 32'h80AABBCC);
    issue(1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
    chk("lb_sel", 64'(sel_o), 64'b1000);
    chk("lb_adr", 64'(adr_o), 64'h100);
    chk("lb_busy", 64'(busy), 1);
    wait_idle();
    chk("lb_rdata", 64'(rdata), 64'hFFFFFF80);
    issue(1'b1, 2'b01, 1'b0, 32'h2, 32'h1234);
    chk("sh_sel", 64'(sel_o), 64'b1100);
    chk("sh_dat", 64'(dat_o[31:16]), 64'h1234);
    chk("sh_we", 64'(we_o), 1);
    lat_to_done(c);
    chk("sh_latency", 64'(c), 3);
    issue(1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
    chk("mis_stb", 64'(stb_o), 0);
    lat_to_done(c);
    chk("mis_latency", 64'(c), 1);
    issue(1'b0, 2'b11, 1'b0, 32'h8, 32'h0);
    chk("dw32_stb", 64'(stb_o), 0);
    fix_hold = 6;
    issue(1'b0, 2'b10, 1'b1, 32'h4, 32'h0);
    lat_to_done(c);
    chk("hold_latency", 64'(c), 8);
    fix_hold = 1;
    wait_idle();
    slave_on = 1'b0;
    drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("abort_stb_pre", 64'(stb_o), 1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("abort_stb", 64'(stb_o), 0);
    chk("abort_busy", 64'(busy), 0);
    chk("abort_rdata", 64'(rdata), 0);
    exp_rd = '0;
    repeat (4) @(negedge clk);
`ifdef LSU_TIMEOUT_EN
    begin
      exp_t x;
      x.e = 2'b10;
      x.r = exp_rd;
      exp_q.push_back(x);
    end
    drive(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    c = 0;
    while (stb_o && c < 50) begin
      c++;
      @(negedge clk);
    end
    chk("tmo_stb_cycles", 64'(c), 8);
    wait_idle();
`endif
    slave_on = 1'b1;
    fix_dly = -1;
    fix_hold = -1;
    repeat (150) begin
      s = 2'($urandom_range(0, 3));
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << s) - 32'd1);
      issue(1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, $urandom);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_lsu.md
BUS_LSU -- requirements
Module: bus_lsu

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, bus data width (32 or 64).
REQ-002 The block SHALL have parameter ADDR_W, default 32, bus byte-address width.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, watchdog limit in cycles (used only under the Configuration macro).
REQ-004 The block SHALL have one clock and a synchronous active-high reset, with the ports listed below.
- clk  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req  in  1  core access request; sampled in IDLE only
- we  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 half, 10 word, 11 dword
- sgn  in  1  sign-extend load result
- addr  in  ADDR_W  byte address
- wdata  in  DATA_W  store data, right-aligned
- rdata  out  DATA_W  load result, right-aligned and extended
- done  out  1  one-cycle completion pulse
- err  out  2  valid with done: 00 ok, 01 misaligned, 10 timeout
- busy  out  1  high whenever the block is not in IDLE
- adr_o  out  ADDR_W  bus address, bus-word aligned (low log2(DATA_W/8) bits zero)
- dat_o  out  DATA_W  bus write data
- sel_o  out  DATA_W/8  byte-lane select
- we_o  out  1  bus write enable
- stb_o  out  1  bus strobe
- dat_i  in  DATA_W  bus read data
- ack_i  in  1  bus acknowledge

Function
REQ-005 The FSM SHALL have the states IDLE, STROBE, RELEASE, and RESP.
REQ-006 In IDLE with req=1, the block SHALL latch we, size, sgn, addr, and wdata; a misaligned access SHALL go to RESP with err=01 and no bus cycle; any other access SHALL go to STROBE.
REQ-007 An access SHALL be treated as misaligned when addr is not a multiple of 2^size, or when size=11 with DATA_W=32.
REQ-008 On the entry cycle of STROBE, the block SHALL register stb_o=1, we_o, adr_o=addr with the low lane bits cleared, sel_o=(2^(2^size)-1) shifted left by the lane offset, and dat_o=wdata shifted left by 8 x the lane offset; these outputs SHALL be held stable until ack_i.
REQ-009 In STROBE with ack_i=1, the block SHALL capture dat_i for a load, set stb_o=0 and we_o=0 on the next edge, and go to RELEASE.
REQ-010 In RELEASE, the block SHALL wait for ack_i=0 and then go to RESP; ack_i held high SHALL keep the block in RELEASE.
REQ-011 In RESP, the block SHALL pulse done for exactly one cycle, drive err, drive rdata for a load, and return to IDLE; req SHALL be ignored outside IDLE.
REQ-012 Load result: the selected lanes SHALL be shifted down to bit 0, and the upper bits SHALL be zero-filled, or filled with the top selected bit when sgn=1; for a store, rdata SHALL hold its previous value.
REQ-013 The minimum latency from req to done SHALL be 4 cycles with ack_i asserted one cycle after stb_o and dropped one cycle later; a misaligned access SHALL complete in 2 cycles.
REQ-014 A new req SHALL be accepted on the cycle following done, allowing back-to-back accesses.
REQ-015 Lane offset arithmetic SHALL use addr[log2(DATA_W/8)-1:0] only, and address bits above the lane field SHALL pass through unmodified.

Reset
REQ-016 With rst_i=1 at a clock edge, the block SHALL go to IDLE and drive stb_o=0, we_o=0, done=0, err=00, busy=0, sel_o=0, adr_o=0, dat_o=0, and rdata=0.
REQ-017 A reset asserted mid-transfer SHALL drop stb_o on the same edge, and no done SHALL be issued for the aborted access.

Configuration
REQ-018 With macro LSU_TIMEOUT_EN defined, a cycle counter SHALL run in STROBE; if it reaches TIMEOUT with no ack_i, the block SHALL drop stb_o, go to RESP with err=10, and leave rdata unchanged.
REQ-019 Without LSU_TIMEOUT_EN, no counter SHALL be implemented, STROBE SHALL wait indefinitely, and err SHALL never be 10.

Verification
REQ-020 Byte load, DATA_W=32: addr=0x103, sgn=1, dat_i=0x80AABBCC -> sel_o=1000, adr_o=0x100, rdata=0xFFFFFF80, err=00.
REQ-021 Half store: addr=0x2, wdata=0x1234 -> sel_o=1100, dat_o[31:16]=0x1234, we_o=1 until ack_i, done 4 cycles after req.
REQ-022 Misaligned: word load at addr=0x6 -> no stb_o, done after 2 cycles, err=01.
REQ-023 DATA_W=64: dword load at addr=0x8 -> sel_o=0xFF; dword load with DATA_W=32 -> err=01.
REQ-024 Hold ack_i high 5 cycles after the strobe drops -> the block stays in RELEASE and done is issued only after ack_i falls; rst_i pulsed in STROBE -> stb_o=0 on the next edge, with no done.
REQ-025 With LSU_TIMEOUT_EN and TIMEOUT=8, never assert ack_i -> stb_o drops, done is issued with err=10, and the next req is accepted normally.
